multi_alarm_scheduler: RTL and testbench

MULTI_ALARM_SCHEDULER -- requirements
Module: multi_alarm_scheduler

---
 rtl/multi_alarm_scheduler.sv | 179 +++++++++++++++++
 tb/tb_multi_alarm_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_scheduler.sv
// Alarm-clock sequencer: per-slot hh:mm match, ring / snooze / auto-dismiss, pending queue.
// Optional ALARM_WEEKDAY_EN adds per-slot day-of-week masks (cur_dow, wr_dow ports).
module multi_alarm_scheduler #(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3,
  localparam int IW = $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_sec,
  input  logic [4:0]            cur_hr,
  input  logic [5:0]            cur_min,
  input  logic [5:0]            cur_sec,
`ifdef ALARM_WEEKDAY_EN
  input  logic [2:0]            cur_dow,
  input  logic [6:0]            wr_dow,
`endif
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [4:0]            wr_hr,
  input  logic [5:0]            wr_min,
  input  logic                  wr_on,
  input  logic                  dismiss_btn,
  input  logic                  snooze_btn,
  output logic                  alarm_buzzer,
  output logic [IW-1:0]         ring_idx,
  output logic [NUM_ALARMS-1:0] slot_on,
  output logic [2:0]            snooze_cnt,
  output logic [NUM_ALARMS-1:0] pending
);

  // state  | meaning
  // IDLE   | nothing sounding; serves lowest pending slot next edge
  // RING   | buzzer on; ring counter runs down to auto-dismiss
  // SNOOZE | buzzer off; snooze counter runs down, then rings again
  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  localparam logic [11:0]           RING_LOAD   = 12'(RING_SEC);
  localparam logic [11:0]           SNOOZE_LOAD = 12'(SNOOZE_SEC);
  localparam logic [2:0]            MAX_SN      = 3'(MAX_SNOOZE);
  localparam logic [NUM_ALARMS-1:0] ONE         = NUM_ALARMS'(1);

  state_t                state, state_n;
  logic [11:0]           cnt, cnt_n;
  logic [IW-1:0]         ring_idx_n, lowest_idx;
  logic [2:0]            snooze_cnt_n;
  logic [NUM_ALARMS-1:0] pending_n, match, active_mask, served_clr, wr_clr;
  logic                  wr_ok;

  logic [4:0] slot_hr  [NUM_ALARMS];
  logic [5:0] slot_min [NUM_ALARMS];
`ifdef ALARM_WEEKDAY_EN
  logic [6:0] slot_dow [NUM_ALARMS];
`endif

  assign alarm_buzzer = (state == S_RING);
  assign wr_ok = wr_en && (wr_hr <= 5'd23) && (wr_min <= 6'd59) &&
                 ({1'b0, wr_idx} < (IW+1)'(NUM_ALARMS));

  // Matching reads the registered slot contents, so a same-cycle write cannot affect it.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (tick_sec && (cur_sec == 6'd0) && slot_on[i] &&
          (cur_hr == slot_hr[i]) && (cur_min == slot_min[i])
`ifdef ALARM_WEEKDAY_EN
          && (((slot_dow[i] >> cur_dow) & 7'd1) != 7'd0)
`endif
         )
        match[i] = 1'b1;
    end
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_ALARMS-1; i >= 0; i--) begin
      if (pending[i]) lowest_idx = IW'(i);
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    ring_idx_n   = ring_idx;
    snooze_cnt_n = snooze_cnt;
    served_clr   = '0;
    case (state)
      S_IDLE: begin
        if (pending != '0) begin
          state_n      = S_RING;
          ring_idx_n   = lowest_idx;
          served_clr   = ONE << lowest_idx;
          cnt_n        = RING_LOAD;
          snooze_cnt_n = 3'd0;
        end
      end
      S_RING: begin
        if (dismiss_btn) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (snooze_btn) begin
          if (snooze_cnt < MAX_SN) begin
            state_n      = S_SNOOZE;
            snooze_cnt_n = snooze_cnt + 3'd1;
            cnt_n        = SNOOZE_LOAD;
          end else begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end
        end else if (tick_sec) begin
          if (cnt <= 12'd1) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 12'd1;
          end
        end
      end
      S_SNOOZE: begin
        if (dismiss_btn) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (tick_sec) begin
          if (cnt <= 12'd1) begin
            state_n = S_RING;
            cnt_n   = RING_LOAD;
          end else begin
            cnt_n = cnt - 12'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    active_mask = (state != S_IDLE) ? (ONE << ring_idx) : '0;
    wr_clr      = (wr_ok && !wr_on) ? (ONE << wr_idx) : '0;
    pending_n   = (pending | (match & ~active_mask)) & ~served_clr & ~wr_clr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ring_idx   <= '0;
      snooze_cnt <= '0;
      pending    <= '0;
      slot_on    <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hr[i]  <= '0;
        slot_min[i] <= '0;
`ifdef ALARM_WEEKDAY_EN
        slot_dow[i] <= 7'h7F;
`endif
      end
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ring_idx   <= ring_idx_n;
      snooze_cnt <= snooze_cnt_n;
      pending    <= pending_n;
      if (wr_ok) begin
        slot_hr[wr_idx]  <= wr_hr;
        slot_min[wr_idx] <= wr_min;
        slot_on[wr_idx]  <= wr_on;
`ifdef ALARM_WEEKDAY_EN
        slot_dow[wr_idx] <= wr_dow;
`endif
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_scheduler.sv
// Self-checking bench for multi_alarm_scheduler: directed scenarios plus randomized traffic
// compared against a seconds-level behavioural model of the alarm rules.
module tb_multi_alarm_scheduler;
  localparam int NA = 4;
  localparam int SN = 5;
  localparam int RS = 60;
  localparam int MS = 3;
  localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;

  logic clk = 1'b0;
  logic reset, tick_sec, wr_en, wr_on, dismiss_btn, snooze_btn;
  logic [4:0] cur_hr, wr_hr;
  logic [5:0] cur_min, cur_sec, wr_min;
  logic [1:0] wr_idx;
`ifdef ALARM_WEEKDAY_EN
  logic [2:0] cur_dow;
  logic [6:0] wr_dow;
`endif
  logic alarm_buzzer;
  logic [1:0] ring_idx;
  logic [NA-1:0] slot_on, pending;
  logic [2:0] snooze_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // reference model
  int m_hr[NA];
  int m_min[NA];
  logic [NA-1:0] m_on, m_pend;
`ifdef ALARM_WEEKDAY_EN
  logic [6:0] m_dow[NA];
`endif
  int m_mode, m_left, m_snz;
  logic [1:0] m_slot;

  multi_alarm_scheduler #(.NUM_ALARMS(NA), .SNOOZE_SEC(SN), .RING_SEC(RS), .MAX_SNOOZE(MS)) dut (
    .clk(clk), .reset(reset), .tick_sec(tick_sec),
    .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
`ifdef ALARM_WEEKDAY_EN
    .cur_dow(cur_dow), .wr_dow(wr_dow),
`endif
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hr(wr_hr), .wr_min(wr_min), .wr_on(wr_on),
    .dismiss_btn(dismiss_btn), .snooze_btn(snooze_btn),
    .alarm_buzzer(alarm_buzzer), .ring_idx(ring_idx), .slot_on(slot_on),
    .snooze_cnt(snooze_cnt), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [NA-1:0] hits, nxt;
    int low;
    if (reset !== 1'b1) begin
      m_mode = M_IDLE; m_left = 0; m_snz = 0; m_slot = 2'd0; m_pend = '0; m_on = '0;
      for (int i = 0; i < NA; i++) begin
        m_hr[i] = 0; m_min[i] = 0;
`ifdef ALARM_WEEKDAY_EN
        m_dow[i] = 7'h7F;
`endif
      end
      return;
    end
    hits = '0;
    if (tick_sec && cur_sec == 6'd0)
      for (int i = 0; i < NA; i++)
        if (m_on[i] && int'(cur_hr) == m_hr[i] && int'(cur_min) == m_min[i]
`ifdef ALARM_WEEKDAY_EN
            && m_dow[i][cur_dow]
`endif
           ) hits[i] = 1'b1;
    if (m_mode != M_IDLE) hits[m_slot] = 1'b0;
    nxt = m_pend | hits;
    if (wr_en && wr_hr < 5'd24 && wr_min < 6'd60) begin
      m_hr[wr_idx] = int'(wr_hr);
      m_min[wr_idx] = int'(wr_min);
      m_on[wr_idx] = wr_on;
`ifdef ALARM_WEEKDAY_EN
      m_dow[wr_idx] = wr_dow;
`endif
      if (!wr_on) nxt[wr_idx] = 1'b0;
    end
    case (m_mode)
      M_IDLE: if (m_pend != '0) begin
        low = 0;
        for (int i = NA-1; i >= 0; i--) if (m_pend[i]) low = i;
        m_mode = M_RING; m_slot = 2'(low); m_left = RS; m_snz = 0;
        nxt[low] = 1'b0;
      end
      M_RING: begin
        if (dismiss_btn) m_mode = M_IDLE;
        else if (snooze_btn) begin
          if (m_snz < MS) begin m_mode = M_SNOOZE; m_snz++; m_left = SN; end
          else m_mode = M_IDLE;
        end else if (tick_sec) begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
      default: begin
        if (dismiss_btn) m_mode = M_IDLE;
        else if (tick_sec) begin
          m_left--;
          if (m_left == 0) begin m_mode = M_RING; m_left = RS; end
        end
      end
    endcase
    m_pend = nxt;
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    #1;
    tick_sec = 1'b0; wr_en = 1'b0; dismiss_btn = 1'b0; snooze_btn = 1'b0;
  endtask

  task automatic write_slot(input int idx, input int h, input int m, input logic on);
    wr_en = 1'b1; wr_idx = 2'(idx); wr_hr = 5'(h); wr_min = 6'(m); wr_on = on;
    clk_cycle();
  endtask

  task automatic do_tick(input int h, input int m, input int s);
    cur_hr = 5'(h); cur_min = 6'(m); cur_sec = 6'(s); tick_sec = 1'b1;
    clk_cycle();
  endtask

  task automatic press(input logic dis, input logic snz);
    dismiss_btn = dis; snooze_btn = snz;
    clk_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clk_cycle(); clk_cycle();
    n_checks++; if (alarm_buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer got %0b want 0", alarm_buzzer); end
    n_checks++; if (ring_idx !== 2'd0) begin n_fail++; $display("FAIL reset_ring_idx got %0d want 0", ring_idx); end
    n_checks++; if (snooze_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_snooze_cnt got %0d want 0", snooze_cnt); end
    n_checks++; if (pending !== 4'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0000", pending); end
    n_checks++; if (slot_on !== 4'b0) begin n_fail++; $display("FAIL reset_slot_on got %b want 0000", slot_on); end
    reset = 1'b1;
    clk_cycle();
  endtask

  task automatic test_single_alarm();
    write_slot(1, 7, 30, 1'b1);
    n_checks++; if (slot_on !== 4'b0010) begin n_fail++; $display("FAIL single_slot_on got %b want 0010", slot_on); end
    do_tick(7, 29, 59);
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_early_pending got %b want 0000", pending); end
    do_tick(7, 30, 0);
    n_checks++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL single_pending got %b want 0010", pending); end
    n_checks++; if (alarm_buzzer !== 1'b0) begin n_fail++; $display("FAIL single_buzz_early got %0b want 0", alarm_buzzer); end
    clk_cycle();
    n_checks++; if (alarm_buzzer !== 1'b1) begin n_fail++; $display("FAIL single_buzz got %0b want 1", alarm_buzzer); end
    n_checks++; if (ring_idx !== 2'd1) begin n_fail++; $display("FAIL single_ring_idx got %0d want 1", ring_idx); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_served got %b want 0000", pending); end
    press(1'b1, 1'b0);
    n_checks++; if (alarm_buzzer !== 1'b0) begin n_fail++; $display("FAIL single_dismiss got %0b want 0", alarm_buzzer); end
  endtask

  task automatic test_priority();
    write_slot(0, 6, 0, 1'b1);
    write_slot(2, 6, 0, 1'b1);
    do_tick(6, 0, 0);
    n_checks++; if (pending !== 4'b0101) begin n_fail++; $display("FAIL prio_pending got %b want 0101", pending); end
    clk_cycle();
    n_checks++; if (ring_idx !== 2'd0 || alarm_buzzer !== 1'b1) begin n_fail++; $display("FAIL prio_first got idx %0d buzz %0b want idx 0 buzz 1", ring_idx, alarm_buzzer); end
    n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL prio_left got %b want 0100", pending); end
    press(1'b1, 1'b0);
    n_checks++; if (alarm_buzzer !== 1'b0) begin n_fail++; $display("FAIL prio_dismiss got %0b want 0", alarm_buzzer); end
    clk_cycle();
    n_checks++; if (ring_idx !== 2'd2 || alarm_buzzer !== 1'b1) begin n_fail++; $display("FAIL prio_second got idx %0d buzz %0b want idx 2 buzz 1", ring_idx, alarm_buzzer); end
    press(1'b1, 1'b0);
  endtask

  task automatic test_snooze();
    write_slot(2, 6, 0, 1'b0);
    do_tick(6, 0, 0);
    clk_cycle();
    n_checks++; if (alarm_buzzer !== 1'b1 || snooze_cnt !== 3'd0) begin n_fail++; $display("FAIL snz_start got buzz %0b cnt %0d want 1 0", alarm_buzzer, snooze_cnt); end
    for (int k = 1; k <= MS; k++) begin
      press(1'b0, 1'b1);
      n_checks++; if (alarm_buzzer !== 1'b0 || snooze_cnt !== 3'(k)) begin n_fail++; $display("FAIL snz_enter%0d got buzz %0b cnt %0d want 0 %0d", k, alarm_buzzer, snooze_cnt, k); end
      for (int t = 1; t < SN; t++) do_tick(6, 0, 1);
      n_checks++; if (alarm_buzzer !== 1'b0) begin n_fail++; $display("FAIL snz_hold%0d got %0b want 0", k, alarm_buzzer); end
      do_tick(6, 0, 1);
      n_checks++; if (alarm_buzzer !== 1'b1 || snooze_cnt !== 3'(k) || ring_idx !== 2'd0) begin n_fail++; $display("FAIL snz_rering%0d got buzz %0b cnt %0d idx %0d want 1 %0d 0", k, alarm_buzzer, snooze_cnt, ring_idx, k); end
    end
    press(1'b0, 1'b1);
    for (int t = 0; t < SN + 1; t++) do_tick(6, 0, 1);
    n_checks++; if (alarm_buzzer !== 1'b0 || snooze_cnt !== 3'd3) begin n_fail++; $display("FAIL snz_exhausted got buzz %0b cnt %0d want 0 3", alarm_buzzer, snooze_cnt); end
  endtask

  task automatic test_auto_dismiss();
    do_tick(6, 0, 0);
    clk_cycle();
    do_tick(6, 0, 0);
    n_checks++; if (pending !== 4'b0000 || alarm_buzzer !== 1'b1) begin n_fail++; $display("FAIL auto_self_match got pend %b buzz %0b want 0000 1", pending, alarm_buzzer); end
    for (int t = 2; t < RS; t++) do_tick(6, 0, 5);
    n_checks++; if (alarm_buzzer !== 1'b1) begin n_fail++; $display("FAIL auto_tick59 got %0b want 1", alarm_buzzer); end
    do_tick(6, 0, 5);
    n_checks++; if (alarm_buzzer !== 1'b0) begin n_fail++; $display("FAIL auto_tick60 got %0b want 0", alarm_buzzer); end
    do_tick(6, 0, 0);
    clk_cycle();
    press(1'b1, 1'b1);
    n_checks++; if (alarm_buzzer !== 1'b0 || snooze_cnt !== 3'd0) begin n_fail++; $display("FAIL both_btns got buzz %0b cnt %0d want 0 0", alarm_buzzer, snooze_cnt); end
  endtask

  task automatic test_write_active();
    do_tick(6, 0, 0);
    clk_cycle();
    write_slot(0, 9, 15, 1'b1);
    n_checks++; if (alarm_buzzer !== 1'b1) begin n_fail++; $display("FAIL wr_active_on got %0b want 1", alarm_buzzer); end
    write_slot(0, 9, 15, 1'b0);
    n_checks++; if (alarm_buzzer !== 1'b1 || slot_on !== 4'b0010) begin n_fail++; $display("FAIL wr_active_off got buzz %0b mask %b want 1 0010", alarm_buzzer, slot_on); end
    press(1'b1, 1'b0);
    write_slot(0, 6, 0, 1'b1);
  endtask

  task automatic test_reset_mid_ring();
    do_tick(6, 0, 0);
    clk_cycle();
    reset = 1'b0;
    clk_cycle();
    n_checks++; if (alarm_buzzer !== 1'b0 || ring_idx !== 2'd0 || snooze_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_ring got buzz %0b idx %0d cnt %0d want 0 0 0", alarm_buzzer, ring_idx, snooze_cnt); end
    n_checks++; if (pending !== 4'b0 || slot_on !== 4'b0) begin n_fail++; $display("FAIL rst_ring_masks got pend %b on %b want 0000 0000", pending, slot_on); end
    reset = 1'b1;
    write_slot(1, 7, 30, 1'b1);
    write_slot(1, 24, 0, 1'b0);
    write_slot(1, 7, 60, 1'b0);
    n_checks++; if (slot_on !== 4'b0010) begin n_fail++; $display("FAIL bad_write_on got %b want 0010", slot_on); end
    do_tick(7, 30, 0);
    n_checks++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL bad_write_time got %b want 0010", pending); end
    clk_cycle();
    press(1'b1, 1'b0);
  endtask

`ifdef ALARM_WEEKDAY_EN
  task automatic test_weekday();
    wr_dow = 7'b0000010;
    write_slot(3, 10, 0, 1'b1);
    cur_dow = 3'd0;
    do_tick(10, 0, 0);
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL dow_miss got %b want 0000", pending); end
    cur_dow = 3'd1;
    do_tick(10, 0, 0);
    clk_cycle();
    n_checks++; if (alarm_buzzer !== 1'b1 || ring_idx !== 2'd3) begin n_fail++; $display("FAIL dow_hit got buzz %0b idx %0d want 1 3", alarm_buzzer, ring_idx); end
    press(1'b1, 1'b0);
    wr_dow = 7'h7F;
    cur_dow = 3'd0;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) != 0);
      tick_sec = 1'($urandom_range(0, 1));
      cur_hr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 23)) : 5'(6 + $urandom_range(0, 1));
      cur_min = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 59)) : 6'(30 * $urandom_range(0, 1));
      cur_sec = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
      wr_en = ($urandom_range(0, 9) == 0);
      wr_idx = 2'($urandom_range(0, 3));
      wr_hr = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'(6 + $urandom_range(0, 1));
      wr_min = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'(30 * $urandom_range(0, 1));
      wr_on = ($urandom_range(0, 3) != 0);
      dismiss_btn = ($urandom_range(0, 39) == 0);
      snooze_btn = ($urandom_range(0, 14) == 0);
`ifdef ALARM_WEEKDAY_EN
      cur_dow = 3'($urandom_range(0, 6));
      wr_dow = 7'($urandom_range(0, 127));
`endif
      clk_cycle();
      n_checks++; if (alarm_buzzer !== (m_mode == M_RING)) begin n_fail++; $display("FAIL rnd_buzzer cyc %0d got %0b want %0b", n, alarm_buzzer, (m_mode == M_RING)); end
      n_checks++; if (ring_idx !== m_slot) begin n_fail++; $display("FAIL rnd_ring_idx cyc %0d got %0d want %0d", n, ring_idx, m_slot); end
      n_checks++; if (snooze_cnt !== 3'(m_snz)) begin n_fail++; $display("FAIL rnd_snooze_cnt cyc %0d got %0d want %0d", n, snooze_cnt, m_snz); end
      n_checks++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending cyc %0d got %b want %b", n, pending, m_pend); end
      n_checks++; if (slot_on !== m_on) begin n_fail++; $display("FAIL rnd_slot_on cyc %0d got %b want %b", n, slot_on, m_on); end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; tick_sec = 1'b0; wr_en = 1'b0; wr_on = 1'b0; wr_idx = 2'd0;
    wr_hr = 5'd0; wr_min = 6'd0; dismiss_btn = 1'b0; snooze_btn = 1'b0;
    cur_hr = 5'd0; cur_min = 6'd0; cur_sec = 6'd1;
`ifdef ALARM_WEEKDAY_EN
    cur_dow = 3'd0; wr_dow = 7'h7F;
`endif
    test_reset();
    test_single_alarm();
    test_priority();
    test_snooze();
    test_auto_dismiss();
    test_write_active();
    test_reset_mid_ring();
`ifdef ALARM_WEEKDAY_EN
    test_weekday();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
